mem_port_arbiter: RTL

Shares the single external memory port (8-bit multiplexed address/data out, 8-bit data in, read/write strobes) between two requesters. Typical use: requester 0 is the CPU core, requester 1 is a debug/program loader. Each granted transaction runs the port's two-phase protocol, then returns read data and a done pulse to the winner. Arbitration is round-robin, and a bounded wait timeout protects against a stalled memory.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one two-phase memory port between two requesters
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  input  logic       r1_req,
  input  logic       r0_we,
  input  logic       r1_we,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r0_wdata,
  input  logic [7:0] r1_wdata,
  output logic       r0_done,
  output logic       r1_done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [7:0] bus_out,
  output logic       bus_rd,
  output logic       bus_wr,
  input  logic [7:0] bus_in,
  input  logic       bus_wait
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t     r_state;
  logic       r_last;
  logic       r_id;
  logic       r_we;
  logic [7:0] r_wdata;
  logic [7:0] r_wait_cnt;
  logic [7:0] r_bus_out;
  logic       r_bus_rd;
  logic       r_bus_wr;
  logic       r_done0;
  logic       r_done1;
  logic       r_err;
  logic [7:0] r_rdata;

  logic       w_any;
  logic       w_win;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // On a tie the requester not granted last time wins.
  assign w_any   = r0_req | r1_req;
  assign w_win   = (r0_req & r1_req) ? ~r_last : r1_req;
  assign w_we    = w_win ? r1_we    : r0_we;
  assign w_addr  = w_win ? r1_addr  : r0_addr;
  assign w_wdata = w_win ? r1_wdata : r0_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_wait_cnt <= 8'h00;
      r_bus_out  <= 8'h00;
      r_bus_rd   <= 1'b0;
      r_bus_wr   <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_ADDR;
            r_id       <= w_win;
            r_last     <= w_win;
            r_we       <= w_we;
            r_wdata    <= w_wdata;
            r_wait_cnt <= 8'h00;
            r_bus_out  <= w_addr;
            r_bus_rd   <= ~w_we;
            r_bus_wr   <= w_we;
          end
        end
        S_ADDR: begin
          r_state   <= S_DATA;
          r_bus_out <= r_we ? r_wdata : 8'h00;
          r_bus_rd  <= 1'b0;
          r_bus_wr  <= 1'b0;
        end
        S_DATA: begin
          if (!bus_wait) begin
            r_state   <= S_DONE;
            r_err     <= 1'b0;
            if (!r_we) r_rdata <= bus_in;
            r_bus_out <= 8'h00;
            r_done0   <= ~r_id;
            r_done1   <= r_id;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            // Stalled memory: abort with a recognisable all-ones read value.
            r_state   <= S_DONE;
            r_err     <= 1'b1;
            r_rdata   <= 8'hFF;
            r_bus_out <= 8'h00;
            r_done0   <= ~r_id;
            r_done1   <= r_id;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_out = r_bus_out;
  assign bus_rd  = r_bus_rd;
  assign bus_wr  = r_bus_wr;
  assign r0_done = r_done0;
  assign r1_done = r_done1;
  assign err     = r_err;
  assign rdata   = r_rdata;

endmodule
